// File: rtl/seq_gen101_tx_if.sv
// Pattern/control inputs and serial/golden outputs of the
// 101 stimulus transmitter.
interface seq_gen101_tx_if #(
    parameter int WIDTH = 15,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             load;
    logic             start;
    logic             stop;
    logic             rpt;
    logic [WIDTH-1:0] din;
    logic [LEN_W-1:0] len;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;
    logic             exp_y_mealy;
    logic             exp_y_moore;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output load, start, stop, rpt, din, len,
        input  x, valid, busy, done,
        input  exp_y_mealy, exp_y_moore, hit_cnt
    );

    modport slave (
        input  load, start, stop, rpt, din, len,
        output x, valid, busy, done,
        output exp_y_mealy, exp_y_moore, hit_cnt
    );
endinterface

// File: rtl/seq_gen101_tx.sv
// seq_gen101_tx: MSB-first serial pattern transmitter with golden
// Mealy/Moore 101-detect flags and a saturating hit counter.
module seq_gen101_tx #(
    parameter int WIDTH = 15,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    seq_gen101_tx_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] slen_q, slen_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hist_q, hist_d;
    logic             rpt_q, rpt_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mealy_q, mealy_d;
    logic             moore_q, moore_d;
    logic [CNT_W-1:0] hit_q, hit_d;

    logic [WIDTH-1:0] in_pat;
    logic [LEN_W-1:0] in_len;
    logic             pres;

    // Zero or oversize lengths mean a full-width pattern.
    function automatic logic [LEN_W-1:0] eff_len(
        input logic [LEN_W-1:0] l
    );
        if (l == '0 || int'(l) > WIDTH) return FULL_LEN;
        return l;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            slen_q  <= FULL_LEN;
            work_q  <= '0;
            cnt_q   <= '0;
            hist_q  <= 2'b00;
            rpt_q   <= 1'b0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mealy_q <= 1'b0;
            moore_q <= 1'b0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            slen_q  <= slen_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            rpt_q   <= rpt_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mealy_q <= mealy_d;
            moore_q <= moore_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        slen_d  = slen_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        rpt_d   = rpt_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        mealy_d = 1'b0;
        moore_d = mealy_q;
        hit_d   = hit_q;
        pres    = 1'b0;
        in_pat  = bus.load ? bus.din : pat_q;
        in_len  = bus.load ? eff_len(bus.len) : slen_q;

        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    pat_d  = bus.din;
                    slen_d = eff_len(bus.len);
                end
                if (bus.start && !bus.stop) begin
                    state_d = SEND;
                    rpt_d   = bus.rpt;
                    hist_d  = 2'b00;
                    hit_d   = '0;
                    work_d  = in_pat;
                    cnt_d   = in_len;
                    pres    = 1'b1;
                end
            end
            SEND: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q == ONE_LEN) begin
                    // Seamless wrap keeps history so cross-pass 101s count.
                    if (rpt_q) begin
                        work_d = pat_q;
                        cnt_d  = slen_q;
                        pres   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    work_d = work_q << 1;
                    cnt_d  = cnt_q - ONE_LEN;
                    pres   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pres) begin
            x_d     = work_d[WIDTH-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
            mealy_d = x_d && (hist_d == 2'b10);
            hist_d  = {hist_d[0], x_d};
            if (mealy_d && hit_d != '1) hit_d = hit_d + CNT_W'(1);
        end
    end

    assign bus.x           = x_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.exp_y_mealy = mealy_q;
    assign bus.exp_y_moore = moore_q;
    assign bus.hit_cnt     = hit_q;

    a_x_valid: assert property (
        @(posedge clk) disable iff (!rst) bus.x |-> bus.valid);
    a_valid_busy: assert property (
        @(posedge clk) disable iff (!rst) bus.valid == bus.busy);
    a_done_idle: assert property (
        @(posedge clk) disable iff (!rst) bus.done |-> !bus.valid);
endmodule
